// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I datapath (master) and the hazard unit (slave).
// Carries stage register ids, memory handshake, bank enables/flushes, forward selects and counters.
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic             ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemAccessM, dmem_ready;
    logic             weF, weD, weE, weM, weW;
    logic             flushD, flushE, flushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             fault;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    modport master (
        output rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        output ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemAccessM, dmem_ready,
        input  weF, weD, weE, weM, weW, flushD, flushE, flushW,
        input  ForwardAE, ForwardBE, fault, stall_cycles, flush_events
    );

    modport slave (
        input  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW,
        input  ResultSrcE0, PCSrcE, RegWriteM, RegWriteW, MemAccessM, dmem_ready,
        output weF, weD, weE, weM, weW, flushD, flushE, flushW,
        output ForwardAE, ForwardBE, fault, stall_cycles, flush_events
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard unit: bank enables/flushes, EX forwarding, load-use and memory-wait stalls; PIPE_PERF_CNT_EN adds perf counters.
// Latency: all controls combinational from inputs and current state; state/counters update on clk.
// Backpressure: dmem_ready low freezes F..M banks, times out into a sticky fault after MEM_TIMEOUT waits.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                    clk,
    input  logic                    reset_n,
    pipeline_hazard_ctrl_if.slave   hz
);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_V = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              lw_stall, mem_stall;

    assign lw_stall  = hz.ResultSrcE0 && (hz.rdE != 5'd0) &&
                       ((hz.rdE == hz.rs1D) || (hz.rdE == hz.rs2D));
    assign mem_stall = ((state_q == RUN) && hz.MemAccessM && !hz.dmem_ready) ||
                       ((state_q == MEM_WAIT) && !hz.dmem_ready);

    // M result is younger than W, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic rw_m, input logic [4:0] rd_m,
                                           input logic rw_w, input logic [4:0] rd_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (rw_m && (rd_m != 5'd0) && (rd_m == rs))
            sel = 2'b10;
        else if (rw_w && (rd_w != 5'd0) && (rd_w == rs))
            sel = 2'b01;
        return sel;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        hz.weF       = 1'b1;
        hz.weD       = 1'b1;
        hz.weE       = 1'b1;
        hz.weM       = 1'b1;
        hz.weW       = 1'b1;
        hz.flushD    = 1'b0;
        hz.flushE    = 1'b0;
        hz.flushW    = 1'b0;
        hz.fault     = 1'b0;
        hz.ForwardAE = fwd_sel(hz.rs1E, hz.RegWriteM, hz.rdM, hz.RegWriteW, hz.rdW);
        hz.ForwardBE = fwd_sel(hz.rs2E, hz.RegWriteM, hz.rdM, hz.RegWriteW, hz.rdW);

        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == TIMEOUT_V) begin
                    state_d = FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            FAULT: ;
            default: state_d = RUN;
        endcase

        if (state_q == FAULT) begin
            {hz.weF, hz.weD, hz.weE, hz.weM, hz.weW} = 5'b00000;
            {hz.flushD, hz.flushE, hz.flushW}       = 3'b111;
            hz.fault                                = 1'b1;
        end else if (mem_stall) begin
            // WB still drains, but as a bubble so the stalled M instruction retires once.
            {hz.weF, hz.weD, hz.weE, hz.weM} = 4'b0000;
            hz.flushW                        = 1'b1;
        end else if (lw_stall) begin
            hz.weF    = 1'b0;
            hz.weD    = 1'b0;
            hz.flushE = 1'b1;
        end else if (hz.PCSrcE) begin
            hz.flushD = 1'b1;
            hz.flushE = 1'b1;
        end

        if (!reset_n) begin
            {hz.weF, hz.weD, hz.weE, hz.weM, hz.weW} = 5'b00000;
            {hz.flushD, hz.flushE, hz.flushW}       = 3'b111;
            hz.ForwardAE                            = 2'b00;
            hz.ForwardBE                            = 2'b00;
            hz.fault                                = 1'b0;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else if (state_q != FAULT) begin
            if (mem_stall || lw_stall)
                stall_q <= stall_q + CNT_W'(1);
            else if (hz.PCSrcE)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign hz.stall_cycles = stall_q;
    assign hz.flush_events = flush_q;
`else
    assign hz.stall_cycles = '0;
    assign hz.flush_events = '0;
`endif
endmodule
